// File: rtl/slot_game_controller.sv
// Game controller for a three-reel slot: takes a 1-credit bet, pulses the RNG, captures reels,
// classifies the result and pays winnings one credit per cycle with a coin pulse per credit.
module slot_game_controller #(
  parameter logic [7:0] INIT_CREDITS = 8'd10,
  parameter logic [7:0] JACKPOT_PAY  = 8'd50,
  parameter logic [7:0] TRIPLE_PAY   = 8'd10,
  parameter logic [7:0] PAIR_PAY     = 8'd2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_btn,
  input  logic [2:0] rng1,
  input  logic [2:0] rng2,
  input  logic [2:0] rng3,
  output logic       spin_out,
  output logic [2:0] reel1,
  output logic [2:0] reel2,
  output logic [2:0] reel3,
  output logic [1:0] win_class,
  output logic [7:0] last_payout,
  output logic       coin_pulse,
  output logic [7:0] credits,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, SPIN, CAPTURE, PAYOUT} state_t;

  state_t     r_state;
  state_t     w_next_state;
  logic [7:0] r_credits;
  logic [7:0] r_pay_cnt;
  logic [2:0] r_reel1, r_reel2, r_reel3;
  logic [1:0] r_win_class;
  logic [7:0] r_last_payout;
  logic       w_start_ok;
  logic       w_all_eq;
  logic       w_any_pair;
  logic [1:0] w_class;
  logic [7:0] w_payout;

  assign w_start_ok = start_btn && (r_credits != 8'd0);
  assign w_all_eq   = (rng1 == rng2) && (rng2 == rng3);
  assign w_any_pair = (rng1 == rng2) || (rng2 == rng3) || (rng1 == rng3);

  // Classify the live RNG outputs; only consumed on the CAPTURE edge.
  always_comb begin
    w_class  = 2'd0;
    w_payout = 8'd0;
    if (w_all_eq && (rng1 == 3'd7)) begin
      w_class  = 2'd3;
      w_payout = JACKPOT_PAY;
    end else if (w_all_eq) begin
      w_class  = 2'd2;
      w_payout = TRIPLE_PAY;
    end else if (w_any_pair) begin
      w_class  = 2'd1;
      w_payout = PAIR_PAY;
    end else begin
      w_class  = 2'd0;
      w_payout = 8'd0;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_start_ok) w_next_state = SPIN; else w_next_state = IDLE;
      SPIN:    w_next_state = CAPTURE;
      CAPTURE: if (w_payout != 8'd0) w_next_state = PAYOUT; else w_next_state = IDLE;
      PAYOUT:  if (r_pay_cnt == 8'd1) w_next_state = IDLE; else w_next_state = PAYOUT;
      default: w_next_state = IDLE;
    endcase
  end

  // Credits, captured reels, result and remaining-payout counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_credits     <= INIT_CREDITS;
      r_pay_cnt     <= 8'd0;
      r_reel1       <= 3'd0;
      r_reel2       <= 3'd0;
      r_reel3       <= 3'd0;
      r_win_class   <= 2'd0;
      r_last_payout <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start_ok) r_credits <= r_credits - 8'd1;
        end
        CAPTURE: begin
          r_reel1       <= rng1;
          r_reel2       <= rng2;
          r_reel3       <= rng3;
          r_win_class   <= w_class;
          r_last_payout <= w_payout;
          r_pay_cnt     <= w_payout;
        end
        PAYOUT: begin
          if (r_credits != 8'hFF) r_credits <= r_credits + 8'd1;
          r_pay_cnt <= r_pay_cnt - 8'd1;
        end
        default: begin
        end
      endcase
    end
  end

  assign spin_out    = (r_state == SPIN);
  assign coin_pulse  = (r_state == PAYOUT);
  assign busy        = (r_state != IDLE);
  assign credits     = r_credits;
  assign reel1       = r_reel1;
  assign reel2       = r_reel2;
  assign reel3       = r_reel3;
  assign win_class   = r_win_class;
  assign last_payout = r_last_payout;

endmodule

// File: tb/tb_slot_game_controller.sv
// Self-checking bench for slot_game_controller: table of games scored through a queue,
// plus hand sequences for zero credits, saturation and reset during payout.
module tb_slot_game_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_btn;
  logic [2:0] rng1, rng2, rng3;
  logic       spin_out, coin_pulse, busy;
  logic [2:0] reel1, reel2, reel3;
  logic [1:0] win_class;
  logic [7:0] last_payout, credits;

  int n_checks = 0;
  int n_fail   = 0;
  int m_credits;

  typedef struct {
    logic [2:0] r1, r2, r3;
    logic [1:0] cls;
    int         pay;
    logic       lock;
  } vec_t;

  typedef struct {
    vec_t v;
    int   credits;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[8];

  slot_game_controller dut (
    .clk(clk), .reset(reset), .start_btn(start_btn),
    .rng1(rng1), .rng2(rng2), .rng3(rng3),
    .spin_out(spin_out), .reel1(reel1), .reel2(reel2), .reel3(reel3),
    .win_class(win_class), .last_payout(last_payout), .coin_pulse(coin_pulse),
    .credits(credits), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_credits = 10;
  endtask

  task automatic play_game(input vec_t v);
    exp_t e;
    int spins, coins, cyc, bet;
    bet = m_credits - 1;
    m_credits = (bet + v.pay > 255) ? 255 : bet + v.pay;
    e.v = v;
    e.credits = m_credits;
    sb.push_back(e);
    rng1 = v.r1; rng2 = v.r2; rng3 = v.r3;
    start_btn = 1'b1;
    @(negedge clk);
    spins = 0; coins = 0;
    for (cyc = 0; cyc < 300; cyc++) begin
      if (cyc == 0) chk("bet", credits, bet);
      if (spin_out) spins++;
      if (coin_pulse) coins++;
      start_btn = 1'b0;
      if (!busy) break;
      if (v.lock) start_btn = cyc[0];
      @(negedge clk);
    end
    start_btn = 1'b0;
    e = sb.pop_front();
    chk("idle_after_game", busy, 0);
    chk("game_cycles", cyc, 2 + e.v.pay);
    chk("spin_count", spins, 1);
    chk("coin_count", coins, e.v.pay);
    chk("reel1", reel1, e.v.r1);
    chk("reel2", reel2, e.v.r2);
    chk("reel3", reel3, e.v.r3);
    chk("win_class", win_class, e.v.cls);
    chk("last_payout", last_payout, e.v.pay);
    chk("credits", credits, e.credits);
  endtask

  initial begin
    vec_t v;
    int spins, busys, coins;
    vecs[0] = '{3'd5, 3'd6, 3'd7, 2'd0, 0,  1'b0};
    vecs[1] = '{3'd7, 3'd7, 3'd7, 2'd3, 50, 1'b1};
    vecs[2] = '{3'd3, 3'd1, 3'd3, 2'd1, 2,  1'b0};
    vecs[3] = '{3'd4, 3'd4, 3'd4, 2'd2, 10, 1'b1};
    vecs[4] = '{3'd1, 3'd3, 3'd3, 2'd1, 2,  1'b1};
    vecs[5] = '{3'd2, 3'd2, 3'd5, 2'd1, 2,  1'b0};
    vecs[6] = '{3'd0, 3'd0, 3'd0, 2'd2, 10, 1'b0};
    vecs[7] = '{3'd6, 3'd5, 3'd6, 2'd1, 2,  1'b1};

    reset = 1'b1; start_btn = 1'b0;
    rng1 = 3'd0; rng2 = 3'd0; rng3 = 3'd0;
    m_credits = 10;
    repeat (2) @(negedge clk);
    chk("rst_credits", credits, 10);
    chk("rst_busy", busy, 0);
    chk("rst_spin", spin_out, 0);
    chk("rst_coin", coin_pulse, 0);
    chk("rst_reels", {reel1, reel2, reel3}, 0);
    chk("rst_class", win_class, 0);
    chk("rst_payout", last_payout, 0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) play_game(vecs[i]);

    // Drain credits with losing games, then a held start must do nothing.
    do_reset();
    for (int i = 0; i < 10; i++) play_game(vecs[0]);
    chk("drained", credits, 0);
    start_btn = 1'b1;
    spins = 0; busys = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (spin_out) spins++;
      if (busy) busys++;
    end
    start_btn = 1'b0;
    chk("zero_spin", spins, 0);
    chk("zero_busy", busys, 0);
    chk("zero_credits", credits, 0);

    // Build to 250 and hit a saturating jackpot.
    do_reset();
    for (int i = 0; i < 4; i++) play_game(vecs[1]);
    for (int i = 0; i < 4; i++) play_game(vecs[3]);
    for (int i = 0; i < 8; i++) play_game(vecs[2]);
    chk("at_250", credits, 250);
    play_game(vecs[1]);
    chk("saturated", credits, 255);

    // Reset on the 20th payout cycle of a jackpot.
    rng1 = 3'd7; rng2 = 3'd7; rng3 = 3'd7;
    start_btn = 1'b1;
    @(negedge clk);
    start_btn = 1'b0;
    coins = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (coin_pulse) coins++;
      if (coins == 20) break;
      @(negedge clk);
    end
    chk("abort_reached", coins, 20);
    chk("abort_pre_payout", last_payout, 50);
    reset = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_coin", coin_pulse, 0);
    chk("abort_credits", credits, 10);
    chk("abort_payout", last_payout, 0);
    chk("abort_class", win_class, 0);
    @(negedge clk);
    reset = 1'b0;
    m_credits = 10;
    @(negedge clk);
    chk("abort_stays_idle", busy, 0);
    chk("abort_no_coin", coin_pulse, 0);
    v = vecs[5];
    play_game(v);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/slot_game_controller.md
Name: slot_game_controller

Overview:
- Game-side consumer of the three-reel RNG block.
- Accepts a player start button and deducts a 1-credit bet.
- Issues a one-cycle spin pulse to the RNG block's button_press input, then captures the three reel values it returns.
- Classifies the result, pays winnings into a credit register one credit per cycle, and raises a coin pulse for each credit paid.

Parameters:
- INIT_CREDITS, 8'd10, credit balance loaded at reset.
- JACKPOT_PAY, 8'd50, payout when all three reels equal 3'd7.
- TRIPLE_PAY, 8'd10, payout when all three reels are equal and not 7.
- PAIR_PAY, 8'd2, payout when exactly two reels are equal.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start_btn  input  1  player start request, level-sampled.
- rng1  input  3  reel 1 value from the RNG block.
- rng2  input  3  reel 2 value from the RNG block.
- rng3  input  3  reel 3 value from the RNG block.
- spin_out  output  1  drives the RNG block's button_press; high for exactly one cycle per game.
- reel1  output  3  captured reel 1 value.
- reel2  output  3  captured reel 2 value.
- reel3  output  3  captured reel 3 value.
- win_class  output  2  result class: 0 none, 1 pair, 2 triple, 3 jackpot.
- last_payout  output  8  payout amount of the most recent game.
- coin_pulse  output  1  high for one cycle per credit paid.
- credits  output  8  current credit balance.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (async, immediate, also mid-game):
  - state goes to IDLE; credits = INIT_CREDITS.
  - reel1/2/3 = 0, win_class = 0, last_payout = 0.
  - internal pay counter = 0; spin_out, coin_pulse and busy = 0.
- FSM states: IDLE, SPIN, CAPTURE, PAYOUT. spin_out, coin_pulse and busy are Moore outputs decoded from state.
- IDLE:
  - If start_btn=1 and credits!=0: credits <= credits-1 and next state is SPIN.
  - If start_btn=1 and credits==0: the request is ignored and the state stays IDLE.
- SPIN:
  - spin_out=1 for this single cycle; next state CAPTURE.
  - The RNG block registers new reels on this same edge, so the values are valid on its outputs during CAPTURE.
- CAPTURE, at the edge:
  - Latch rng1..3 into reel1..3.
  - Compute win_class and payout combinationally from the rng inputs, not the old reel regs:
    - all equal and equal to 7 -> class 3, JACKPOT_PAY;
    - all equal, otherwise -> class 2, TRIPLE_PAY;
    - exactly two equal (any pair) -> class 1, PAIR_PAY;
    - otherwise -> class 0, payout 0.
  - last_payout <= payout; pay counter <= payout.
  - Next state is PAYOUT if payout!=0, else IDLE.
- PAYOUT, each cycle:
  - coin_pulse=1.
  - credits <= credits+1, saturating at 8'hFF; coin_pulse still asserts when saturated.
  - Pay counter decrements.
  - When the pay counter equals 1 at the edge, next state is IDLE.
  - Exactly payout coin pulses occur, on consecutive cycles.
- Latency: start edge to spin_out = 1 cycle; spin_out to reels and win_class valid = 2 cycles; payout duration = payout cycles.
- start_btn while busy: ignored and not queued. A held start_btn re-triggers a new game on the first IDLE cycle, provided credits!=0.
- reel1..3, win_class and last_payout hold until the next CAPTURE.
- rng inputs are ignored outside CAPTURE.
- Width rules: credits and payout arithmetic are unsigned 8-bit. Decrement occurs only when credits!=0, so no underflow is possible.
- Reset asserted during PAYOUT aborts the remaining payout. Credits return to INIT_CREDITS.

Test Plan:
- Reset then idle: credits=10, all other outputs 0, busy=0. Pulse start_btn one cycle with rng = 5,6,7 presented during CAPTURE -> credits 9, single spin_out pulse, reels 5,6,7, win_class 0, last_payout 0, no coin_pulse, back in IDLE 3 cycles after start.
- Jackpot: rng = 7,7,7 at CAPTURE -> win_class 3, last_payout 50, 50 consecutive coin_pulse cycles, credits 9+50=59, busy falls after the final pulse.
- Pair and triple:
  - rng = 3,1,3 -> class 1, 2 pulses, net credits +1.
  - rng = 4,4,4 -> class 2, 10 pulses.
- Zero credits: set credits to 0 via 10 losing games, then hold start_btn -> no spin_out, credits stay 0, busy stays 0.
- Saturation: reach credits=250, then a jackpot -> 50 coin pulses, credits stick at 255.
- Reset mid-operation and busy lockout:
  - Assert reset on the 20th payout cycle -> immediate IDLE, credits=10, coin_pulse=0.
  - start_btn pulses during SPIN, CAPTURE or PAYOUT -> no extra spin_out, no extra credit deducted.
